// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default widths for the data-RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCpu  = 2'd1,
    StDbg  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnP0   = 2'd1,
    OwnP1   = 2'd2
  } owner_e;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of cycles the debug port has waited behind the MEM stage.
module ram_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dbg_req_i,
  input  logic cpu_gnt_i,
  input  logic dbg_gnt_i,
  output logic force_dbg_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dbg_gnt_i || !dbg_req_i) begin
      cnt_d = '0;
    end else if (cpu_gnt_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_dbg_o = (cnt_q == CntMax);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for the single-port data RAM (port 0 = MEM stage, port 1 = debug loader).
// Optional perf counters enabled by defining RAM_ARB_PERF_CNT_EN.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       cpu_stall_cycles,
  output logic [31:0]       dbg_grant_count
`endif
);

  arb_state_e        state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              force_dbg;

  ram_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i      (clk),
    .rst_ni     (reset),
    .dbg_req_i  (dbg_req),
    .cpu_gnt_i  (cpu_gnt),
    .dbg_gnt_i  (dbg_gnt),
    .force_dbg_o(force_dbg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_owner_q <= OwnNone;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (cpu_gnt) begin
      state_d = StCpu;
    end else if (dbg_gnt) begin
      state_d = StDbg;
    end
    rd_owner_d = OwnNone;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OwnP0;
    end else if (dbg_gnt && !dbg_we) begin
      rd_owner_d = OwnP1;
    end
  end

  // Requests are masked while reset is held so every output reads zero.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if ((state_q == StDbg) && dbg_lock && dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req && dbg_req) begin
        dbg_gnt = force_dbg;
        cpu_gnt = !force_dbg;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_re    = !cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      ram_we    = dbg_we;
      ram_re    = !dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_gnt;

  // Read data passes straight through in the return cycle and is held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (rd_owner_q == OwnP0) cpu_rdata_q <= ram_rdata;
      if (rd_owner_q == OwnP1) dbg_rdata_q <= ram_rdata;
    end
  end

  assign cpu_rvalid = (rd_owner_q == OwnP0);
  assign dbg_rvalid = (rd_owner_q == OwnP1);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : dbg_rdata_q;

`ifdef RAM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_stall_cycles <= '0;
      dbg_grant_count  <= '0;
    end else begin
      if (cpu_stall) cpu_stall_cycles <= cpu_stall_cycles + 32'd1;
      if (dbg_gnt)   dbg_grant_count  <= dbg_grant_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: rule-level model, behavioural RAM, decoupled read monitor.
module tb_ram_port_arbiter;

  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, ram_we, ram_re;
  logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
`ifdef RAM_ARB_PERF_CNT_EN
  logic [31:0] cpu_stall_cycles, dbg_grant_count;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef RAM_ARB_PERF_CNT_EN
    , .cpu_stall_cycles(cpu_stall_cycles), .dbg_grant_count(dbg_grant_count)
`endif
  );

  // Behavioural synchronous RAM driven only by the DUT's strobes.
  logic [31:0] ram_mem [int];
  always @(posedge clk) begin
    if (ram_we) ram_mem[int'(ram_addr[9:2])] = ram_wdata;
    if (ram_re) ram_rdata <= ram_mem.exists(int'(ram_addr[9:2])) ? ram_mem[int'(ram_addr[9:2])] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] model_mem [int];
  int          starve   = 0;
  bit          dbg_owns = 1'b0;
  int          obs_dbg_gnt, obs_stall, obs_dbg_run;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return model_mem.exists(int'(a[9:2])) ? model_mem[int'(a[9:2])] : 32'h0;
  endfunction

  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input bit dreq, input bit dwe, input bit dlock,
                      input logic [31:0] daddr, input logic [31:0] dwd);
    bit ec, ed;
    @(posedge clk);
    #1;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = daddr; dbg_wdata = dwd;
    @(negedge clk);
    ec = 1'b0;
    ed = 1'b0;
    if (dbg_owns && dlock && dreq) ed = 1'b1;
    else if (creq && dreq) begin
      if (starve == int'(SMAX)) ed = 1'b1;
      else ec = 1'b1;
    end else begin
      ec = creq;
      ed = dreq;
    end
    chk("cpu_gnt", cpu_gnt, ec);
    chk("dbg_gnt", dbg_gnt, ed);
    chk("cpu_stall", cpu_stall, creq & !ec);
    chk("ram_we", ram_we, (ec & cwe) | (ed & dwe));
    chk("ram_re", ram_re, (ec & !cwe) | (ed & !dwe));
    chk("ram_addr", ram_addr, ec ? caddr : (ed ? daddr : 32'h0));
    chk("ram_wdata", ram_wdata, ec ? cwd : (ed ? dwd : 32'h0));
    obs_dbg_gnt += int'(dbg_gnt);
    obs_stall   += int'(cpu_stall);
    obs_dbg_run  = dbg_gnt ? obs_dbg_run + 1 : 0;
    if (ec) begin
      if (cwe) model_mem[int'(caddr[9:2])] = cwd;
      else sb_q.push_back('{0, mem_rd(caddr), cyc + 1});
    end
    if (ed) begin
      if (dwe) model_mem[int'(daddr[9:2])] = dwd;
      else sb_q.push_back('{1, mem_rd(daddr), cyc + 1});
    end
    if (ed || !dreq) starve = 0;
    else if (ec && starve < int'(SMAX)) starve++;
    dbg_owns = ed;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
    chk("rst_ram_strobes", {ram_we, ram_re}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    starve   = 0;
    dbg_owns = 1'b0;
  endtask

  // Read-return monitor, independent of the stimulus.
  logic [31:0] last_cpu = '0, last_dbg = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      last_cpu = '0;
      last_dbg = '0;
    end else begin
      if (cpu_rvalid && dbg_rvalid) chk("rvalid_both", {cpu_rvalid, dbg_rvalid}, 2'b00);
      if (cpu_rvalid || dbg_rvalid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rvalid", {cpu_rvalid, dbg_rvalid}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("rvalid_port", {cpu_rvalid, dbg_rvalid}, (e.port == 0) ? 2'b10 : 2'b01);
          chk("rvalid_latency", cyc, e.due);
          chk("rdata", (e.port == 0) ? cpu_rdata : dbg_rdata, e.data);
          if (e.port == 0) last_cpu = e.data;
          else last_dbg = e.data;
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk("rvalid_missing", {cpu_rvalid, dbg_rvalid}, (e.port == 0) ? 2'b10 : 2'b01);
      end
      if (!cpu_rvalid) chk("cpu_rdata_hold", cpu_rdata, last_cpu);
      if (!dbg_rvalid) chk("dbg_rdata_hold", dbg_rdata, last_dbg);
    end
  end

  initial begin
`ifdef RAM_ARB_PERF_CNT_EN
    logic [31:0] stall0, dgnt0;
`endif
    // Reset with requests active: everything must read zero.
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b1;
    cpu_addr = 32'h40; dbg_addr = 32'h44;
    repeat (2) chk_reset_outputs();
    @(posedge clk);
    #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;

    // Port 0 store then load at 0x10.
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Continuous contention: 4 port-0 grants then 1 port-1 grant, repeating.
    obs_dbg_gnt = 0;
    obs_stall   = 0;
`ifdef RAM_ARB_PERF_CNT_EN
    stall0 = cpu_stall_cycles;
    dgnt0  = dbg_grant_count;
`endif
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 32'h200 + 32'(i * 4), $urandom, 1, 1, 0, 32'h300 + 32'(i * 4), $urandom);
    end
    idle();
    chk("starve_dbg_grants", obs_dbg_gnt, 4);
    chk("starve_cpu_stalls", obs_stall, 4);
`ifdef RAM_ARB_PERF_CNT_EN
    chk("perf_cpu_stall_cycles", cpu_stall_cycles - stall0, 4);
    chk("perf_dbg_grant_count", dbg_grant_count - dgnt0, 4);
`endif

    // Locked debug burst of 8 stores; port 0 joins once port 1 owns the RAM.
    obs_dbg_gnt = 0;
    obs_stall   = 0;
    step(0, 0, 0, 0, 1, 1, 1, 32'h100, 32'hA000_0000);
    for (int i = 1; i < 8; i++) begin
      step(1, 0, 32'h40, 0, 1, 1, 1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    end
    chk("lock_dbg_run", obs_dbg_run, 8);
    chk("lock_cpu_stalls", obs_stall, 7);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("lock_release_cpu_gnt", cpu_gnt, 1);
    idle();

    // Alternating loads from the two ports.
    step(0, 0, 0, 0, 1, 1, 0, 32'h20, 32'h11);
    step(0, 0, 0, 0, 1, 1, 0, 32'h24, 32'h22);
    idle();
    step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h24, 0);
    chk("alt_cpu_rdata", cpu_rdata, 32'h11);
    idle();
    chk("alt_dbg_rdata", dbg_rdata, 32'h22);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 1), 32'($urandom_range(0, 63)) << 2,
           $urandom, $urandom_range(0, 99) < 50, $urandom_range(0, 1),
           $urandom_range(0, 99) < 40, 32'($urandom_range(0, 63)) << 2, $urandom);
    end
    idle();
    idle();

    // Reset in the cycle after a port-0 load grant drops the pending return.
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cpu_req = 1'b1; dbg_req = 1'b1;
    repeat (2) chk_reset_outputs();
    @(posedge clk);
    #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    chk("queue_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
